// File: rtl/ser_pkg.sv
// Shared definitions for the serial receiver/transmitter pair.
//   ser_state_e : frame FSM states (IDLE, DATA, PARITY, STOP), 2-bit encoding
//   DefWidth    : default number of data bits per frame
package ser_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StData   = 2'd1,
      StParity = 2'd2,
      StStop   = 2'd3
   } ser_state_e;

   localparam int unsigned DefWidth = 7;

endpackage

// File: rtl/ser2par_shift.sv
// Data path of the serial receiver: shift register, bit counter and running parity.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart a frame (counter and parity to 0)
//   shift_en  : sample sin into the shift register this cycle
//   sin       : serial data bit
//   shreg     : received data, bit 0 = first bit received
//   par       : XOR of all data bits shifted in since the last clear
//   done      : this shift takes the WIDTH-th data bit
module ser2par_shift
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] shreg,
   output logic             par,
   output logic             done
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] shreg_q;
   logic             par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
      end else if (clear) begin
         cnt_q <= '0;
         par_q <= 1'b0;
      end else if (shift_en) begin
         // LSB-first line: new bits enter at the top and move down
         shreg_q <= {sin, shreg_q[WIDTH-1:1]};
         cnt_q   <= cnt_q + CntW'(1);
         par_q   <= par_q ^ sin;
      end
   end

   // The FSM leaves DATA on this shift, so the counter tops out at WIDTH
   assign done  = shift_en && (cnt_q == CntW'(WIDTH - 1));
   assign shreg = shreg_q;
   assign par   = par_q;

endmodule

// File: rtl/seq_ser2par_rx.sv
// Serial-to-parallel frame receiver.
// Frame: start(0), WIDTH data bits LSB first, optional even parity, stop(1).
//   clk, rst  : clock, asynchronous active-high reset
//   sin       : serial line, idle high, one bit per cycle
//   data_o    : last good frame (held between valid_o strobes)
//   valid_o   : one-cycle strobe, data_o updated
//   par_err_o : one-cycle strobe, parity mismatch, frame dropped
//   frm_err_o : one-cycle strobe, stop bit was 0, frame dropped
//   busy_o    : FSM not idle
module seq_ser2par_rx
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter bit          PAR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             par_err_o,
   output logic             frm_err_o,
   output logic             busy_o
);

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             rx_par_q, rx_par_d;

   logic             clear;
   logic             shift_en;
   logic [WIDTH-1:0] shreg;
   logic             par_calc;
   logic             done;

   ser2par_shift #(
      .WIDTH(WIDTH)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .shift_en(shift_en),
      .sin     (sin),
      .shreg   (shreg),
      .par     (par_calc),
      .done    (done)
   );

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      rx_par_d = rx_par_q;
      clear    = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            clear = 1'b1;
            if (!sin) state_d = StData;
         end
         StData: begin
            shift_en = 1'b1;
            if (done) state_d = PAR_EN ? StParity : StStop;
         end
         StParity: begin
            rx_par_d = sin;
            state_d  = StStop;
         end
         StStop: begin
            // A low stop bit is a framing error and takes precedence over parity
            state_d = StIdle;
            if (!sin) begin
               ferr_d = 1'b1;
            end else if (PAR_EN && (rx_par_q != par_calc)) begin
               perr_d = 1'b1;
            end else begin
               valid_d = 1'b1;
               data_d  = shreg;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         data_q   <= '0;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         rx_par_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         rx_par_q <= rx_par_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign par_err_o = perr_q;
   assign frm_err_o = ferr_q;
   assign busy_o    = (state_q != StIdle);

endmodule

// File: doc/seq_ser2par_rx.md
SEQ_SER2PAR_RX -- requirements
Module: seq_ser2par_rx

Interface
REQ-001 Parameter WIDTH, default 7, number of data bits per frame; legal range 2..16.
REQ-002 Parameter PAR_EN, default 1: 1 = even-parity bit present in the frame, 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sin  input  1  serial line, idle high, synchronous to clk, one bit per cycle.
REQ-006 data_o  output  WIDTH  last good frame; bit 0 is the first data bit received.
REQ-007 valid_o  output  1  one-cycle strobe: data_o was updated.
REQ-008 par_err_o  output  1  one-cycle strobe: parity mismatch, frame dropped.
REQ-009 frm_err_o  output  1  one-cycle strobe: stop bit was 0, frame dropped.
REQ-010 busy_o  output  1  high when the state is not IDLE.

Function
REQ-011 Frame format, in order: start bit (0), WIDTH data bits LSB first, parity bit (only when PAR_EN=1), stop bit (1).
REQ-012 The FSM SHALL have four states, IDLE, DATA, PARITY and STOP, encoded in 2 bits.
REQ-013 IDLE: sin=0 sampled -> DATA with bit counter cleared; sin=1 -> stay in IDLE.
REQ-014 DATA: shift sin into the shift register and increment the counter; after the WIDTH-th bit -> PARITY if PAR_EN=1, else -> STOP.
REQ-015 PARITY: capture sin as the received parity bit -> STOP; expected parity is the XOR of the data bits (even parity).
REQ-016 STOP, sin=1 and parity OK (or PAR_EN=0): load data_o from the shift register, pulse valid_o -> IDLE.
REQ-017 STOP, sin=1 and parity bad: pulse par_err_o, leave data_o unchanged -> IDLE.
REQ-018 STOP, sin=0: pulse frm_err_o only (par_err_o is not asserted, even if parity is also bad), leave data_o unchanged -> IDLE; this 0 is not taken as a new start bit.
REQ-019 Latency: valid_o, par_err_o and frm_err_o are registered and high during the cycle immediately after the clock edge that sampled the stop bit.
REQ-020 The three strobes are mutually exclusive; each is high for exactly one cycle per frame.
REQ-021 Back-to-back frames with zero idle cycles SHALL be received without loss (a start bit may follow the stop bit directly).
REQ-022 The bit counter is $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.
REQ-023 Parity SHALL be computed incrementally in a 1-bit register, with no post-frame reduction cycle.
REQ-024 data_o SHALL hold its value between valid_o strobes.

Reset
REQ-025 rst=1 SHALL force, immediately and without waiting for clk: state = IDLE, counter = 0, shift register = 0, parity register = 0, data_o = 0, and valid_o = par_err_o = frm_err_o = busy_o = 0.
REQ-026 Reset asserted mid-frame discards the partial frame; after release, the first sin=0 sampled is treated as a start bit.

Structure
REQ-027 The state enumeration and the default WIDTH SHALL live in the shared package ser_pkg, which the matching transmitter also uses.
REQ-028 One sub-module, ser2par_shift, SHALL contain the shift register, bit counter and running parity, with controls clear and shift_en and output done; the FSM stays in the top module.

Verification
REQ-029 WIDTH=7, PAR_EN=1; send start, 7'h55 (bits 1,0,1,0,1,0,1), parity 0, stop 1 -> valid_o pulses once, data_o=7'h55, no error strobes.
REQ-030 Same frame with parity bit 1 -> par_err_o pulses once, valid_o stays 0, data_o keeps its previous value.
REQ-031 Frame 7'h3C with stop bit 0 -> frm_err_o pulses once, FSM returns to IDLE; a following good frame 7'h01 -> data_o=7'h01.
REQ-032 Frames 7'h12, 7'h7F, 7'h00 sent back-to-back with no idle cycles -> three valid_o pulses exactly 10 cycles apart, data_o taking 12, 7F, 00 in order.
REQ-033 Assert rst after the 4th data bit of a 7'h6A frame, release it, then send 7'h2B -> all outputs 0 during reset, then a single valid_o with data_o=7'h2B.
REQ-034 PAR_EN=0, WIDTH=8, frame 8'hA5 -> valid_o 9 cycles after the start-bit sampling edge, data_o=8'hA5.
